// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per transaction.
// One Booth step per cycle over a (WIDTH+2)-bit accumulator.
module booth_mult_seq #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH+1:0]   acc, acc_sum, acc_sh, m_ext;
  logic [WIDTH:0]     m_reg, q_reg, q_sh;
  logic               q_m1, sgn, last;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod_nxt, prod_reg;

  assign m_ext   = {m_reg[WIDTH], m_reg};
  assign last    = (cnt <= CNT_W'(1));
  assign product = prod_reg;

  always_comb begin
    acc_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   acc_sum = acc + m_ext;
      2'b10:   acc_sum = acc - m_ext;
      default: acc_sum = acc;
    endcase
    acc_sh = {acc_sum[WIDTH+1], acc_sum[WIDTH+1:1]};
    q_sh   = {acc_sum[0], q_reg[WIDTH:1]};
    // signed runs one step fewer, so Q[0] still holds an unused multiplier bit
    if (sgn)
      prod_nxt = {acc_sh[WIDTH-1:0], q_sh[WIDTH:1]};
    else
      prod_nxt = {acc_sh[WIDTH-2:0], q_sh};
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      q_reg    <= '0;
      m_reg    <= '0;
      q_m1     <= 1'b0;
      sgn      <= 1'b0;
      cnt      <= '0;
      prod_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg <= {in_signed & multiplicand[WIDTH-1], multiplicand};
            q_reg <= {in_signed & multiplier[WIDTH-1], multiplier};
            acc   <= '0;
            q_m1  <= 1'b0;
            sgn   <= in_signed;
            cnt   <= in_signed ? CNT_W'(WIDTH) : CNT_W'(WIDTH + 1);
          end
        end
        ITER: begin
          acc   <= acc_sh;
          q_reg <= q_sh;
          q_m1  <= q_reg[0];
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          if (last) prod_reg <= prod_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: directed table, corner sequences and
// randomized regression at WIDTH 4, 8 and 16 against an integer model.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid, in_signed, out_ready;
  logic [2:0]  in_ready, out_valid, busy;
  logic [15:0] mc, mp;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_signed(in_signed[0]),
    .multiplicand(mc[3:0]), .multiplier(mp[3:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .product(p4), .busy(busy[0])
  );

  booth_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_signed(in_signed[1]),
    .multiplicand(mc[7:0]), .multiplier(mp[7:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .product(p8), .busy(busy[1])
  );

  booth_mult_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_signed(in_signed[2]),
    .multiplicand(mc), .multiplier(mp),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .product(p16), .busy(busy[2])
  );

  typedef struct {
    bit          s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  function automatic int wid(int k);
    return (k == 0) ? 4 : (k == 1) ? 8 : 16;
  endfunction

  function automatic logic [31:0] prod_of(int k);
    case (k)
      0:       return {24'd0, p4};
      1:       return {16'd0, p8};
      default: return p16;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(bit s, logic [15:0] a,
                                          logic [15:0] b, int w);
    longint x, y;
    logic [63:0] r, msk;
    x = longint'(a) & ((longint'(1) << w) - 1);
    y = longint'(b) & ((longint'(1) << w) - 1);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    msk = (64'd1 << (2 * w)) - 64'd1;
    r = 64'(x * y) & msk;
    return r[31:0];
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic txn(input int k, input bit s, input logic [15:0] a,
                     input logic [15:0] b, input bit bp,
                     output logic [31:0] p, output int lat);
    int n;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(in_ready[k]), 32'd1);
    in_valid[k]  = 1'b1;
    in_signed[k] = s;
    mc = a;
    mp = b;
    @(negedge clk);
    in_valid[k]  = 1'b0;
    in_signed[k] = ~s;
    mc = 16'($urandom);
    mp = 16'($urandom);
    lat = 1;
    while (!out_valid[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (bp) begin
      n = $urandom_range(0, 2);
      p = prod_of(k);
      repeat (n) begin
        @(negedge clk);
        chk("bp_hold", prod_of(k), p);
      end
    end
    out_ready[k] = 1'b1;
    p = prod_of(k);
    @(negedge clk);
    out_ready[k] = 1'b0;
    chk("done_one_cycle", 32'(out_valid[k]), 32'd0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] p, snap, exp;
    logic [15:0] a, b;
    int lat, n, w;
    bit s;

    tbl[0] = '{1'b1, 8'h07, 8'hFD, 16'hFFEB, 9};
    tbl[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, 9};
    tbl[2] = '{1'b1, 8'h80, 8'h7F, 16'hC080, 9};
    tbl[3] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 10};
    tbl[4] = '{1'b0, 8'h00, 8'hC8, 16'h0000, 10};
    tbl[5] = '{1'b1, 8'hFF, 8'hFF, 16'h0001, 9};
    tbl[6] = '{1'b0, 8'h80, 8'hFF, 16'h7F80, 10};
    tbl[7] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 9};
    tbl[8] = '{1'b0, 8'h0D, 8'h80, 16'h0680, 10};

    rst = 1'b1;
    in_valid = '0;
    in_signed = '0;
    out_ready = '0;
    mc = '0;
    mp = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h7);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_product", {16'd0, p8}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      txn(1, tbl[i].s, {8'd0, tbl[i].a}, {8'd0, tbl[i].b}, 1'b0, p, lat);
      chk($sformatf("tbl%0d_prod", i), p, {16'd0, tbl[i].p});
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    // backpressure: DONE holds, stray in_valid ignored
    in_valid[1] = 1'b1;
    in_signed[1] = 1'b1;
    mc = 16'h0085;
    mp = 16'h0013;
    exp = ref_mul(1'b1, 16'h0085, 16'h0013, 8);
    @(negedge clk);
    in_valid[1] = 1'b0;
    n = 0;
    while (!out_valid[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    snap = {16'd0, p8};
    chk("bp_prod", snap, exp);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid[1]), 32'd1);
      chk("bp_in_ready", 32'(in_ready[1]), 32'd0);
      chk("bp_stable", {16'd0, p8}, snap);
      in_valid[1] = (i == 2);
      mc = 16'h0011;
      mp = 16'h0022;
      @(negedge clk);
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    chk("hs_in_ready", 32'(in_ready[1]), 32'd0);
    @(negedge clk);
    out_ready[1] = 1'b0;
    chk("post_hs_valid", 32'(out_valid[1]), 32'd0);
    chk("post_hs_ready", 32'(in_ready[1]), 32'd1);
    repeat (12) @(negedge clk);
    chk("no_stray_accept", {30'd0, busy[1], out_valid[1]}, 32'd0);

    // reset mid-ITER, then reset together with in_valid
    in_valid[1] = 1'b1;
    in_signed[1] = 1'b0;
    mc = 16'h00AB;
    mp = 16'h00CD;
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(in_ready[1]), 32'd1);
    chk("mid_rst_valid", 32'(out_valid[1]), 32'd0);
    chk("mid_rst_busy", 32'(busy[1]), 32'd0);
    chk("mid_rst_prod", {16'd0, p8}, 32'd0);
    in_valid[1] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid[1] = 1'b0;
    chk("rst_vs_valid", 32'(busy[1]), 32'd0);
    @(negedge clk);
    chk("rst_vs_valid2", 32'(busy[1]), 32'd0);
    txn(1, 1'b1, 16'd3, 16'd5, 1'b0, p, lat);
    chk("after_rst_3x5", p, 32'h000F);

    // randomized regression
    for (int k = 0; k < 3; k++) begin
      w = wid(k);
      n = (k == 2) ? 1000 : 2000;
      for (int i = 0; i < n; i++) begin
        s = 1'($urandom_range(0, 1));
        a = 16'($urandom);
        b = 16'($urandom);
        if ($urandom_range(0, 7) == 0) a = 16'(1) << (w - 1);
        if ($urandom_range(0, 7) == 0) b = 16'hFFFF;
        txn(k, s, a, b, 1'b1, p, lat);
        chk($sformatf("rnd_w%0d_prod", w), p, ref_mul(s, a, b, w));
        chk($sformatf("rnd_w%0d_lat", w), 32'(lat),
            32'(s ? w + 1 : w + 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
